// File: rtl/nv_ram_rwsthp_19x80_ctrl.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsthp_19x80_ctrl
//
// Valid/ready FIFO controller for one external nv_ram_rwsthp_19x80 instance.
// The RAM read is two-stage: ram_re latches ram_ra into the RAM's address
// register, then ram_ore latches the addressed word (or ram_dbyp when
// ram_byp_sel is set) into the RAM output register. That output register is
// the FIFO head and drives rd_pd directly, so storage is 19 entries + 1 word.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   wr_pvld / wr_prdy / wr_pd        : write stream in
//   rd_pvld / rd_prdy / rd_pd        : read stream out (rd_pd = ram_dout)
//   ram_ra / ram_re / ram_ore        : RAM read address, address enable,
//                                      output-register enable
//   ram_dout                         : RAM output register contents
//   ram_wa / ram_we / ram_di         : RAM write port
//   ram_byp_sel / ram_dbyp           : RAM output bypass select and data
//   fifo_count                       : words held (0..DEPTH+1)
//   pwrbus_ram_pd                    : power bus, only routed to the RAM
// -----------------------------------------------------------------------------
`default_nettype none

module nv_ram_rwsthp_19x80_ctrl #(
  parameter int DEPTH = 19,
  parameter int WIDTH = 80,
  parameter int AW    = 5
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  output logic [AW-1:0]    fifo_count,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);

  // State
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] ram_cnt_q, ram_cnt_d;   // written, not yet captured by ore
  logic          s1_vld_q, s1_vld_d;     // address held in RAM ra_d
  logic          s2_vld_q, s2_vld_d;     // word held in RAM dout_r

  // Combinational control
  logic          wr_acc;
  logic          pop;
  logic          s2_free;
  logic          byp;
  logic          ram_pop;                // ore capturing a RAM-resident word
  logic [AW-1:0] avail;                  // RAM entries not yet address-issued

  // The power bus is only routed to the RAM by the parent.
  logic pwrbus_unused;
  assign pwrbus_unused = ^pwrbus_ram_pd;

  assign wr_prdy = (ram_cnt_q != FULL_CNT);
  assign wr_acc  = wr_pvld & wr_prdy;
  assign rd_pvld = s2_vld_q;
  assign pop     = rd_pvld & rd_prdy;
  assign rd_pd   = ram_dout;

  assign s2_free = ~s2_vld_q | rd_prdy;
  // ram_cnt == 0 guarantees nothing older is in flight, so the new word may
  // go straight into the output register.
  assign byp     = wr_acc & (ram_cnt_q == '0) & s2_free;
  assign ram_ore = s2_free & (s1_vld_q | byp);
  assign ram_pop = ram_ore & ~byp;

  assign ram_byp_sel = byp;
  assign ram_dbyp    = wr_pd;

  assign ram_we = wr_acc & ~byp;
  assign ram_wa = wr_ptr_q;
  assign ram_di = wr_pd;

  // A new address may be latched when ra_d is empty or is being consumed by
  // ore this cycle. The slot itself is freed only at ore, so a write can
  // never land on the address still held in ra_d.
  assign avail  = ram_cnt_q - AW'(s1_vld_q);
  assign ram_re = (avail != '0) & (~s1_vld_q | ram_pop);
  assign ram_ra = rd_ptr_q;

  assign fifo_count = ram_cnt_q + AW'(s2_vld_q);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q + AW'(ram_we) - AW'(ram_pop);
    s1_vld_d  = ram_re | (s1_vld_q & ~ram_ore);
    s2_vld_d  = ram_ore | (s2_vld_q & ~pop);

    if (ram_we) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);
    end
    if (ram_re) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nv_ram_rwsthp_19x80_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nv_ram_rwsthp_19x80_ctrl
//
// Bench for nv_ram_rwsthp_19x80_ctrl. A behavioural RAM (write port, address
// register, output register with bypass mux) closes the loop; an ordered
// queue of accepted words is the reference for what must come out.
// -----------------------------------------------------------------------------
module tb_nv_ram_rwsthp_19x80_ctrl;

  logic        clk;
  logic        rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [79:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [79:0] rd_pd;
  logic [4:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [79:0] ram_dout;
  logic [4:0]  ram_wa;
  logic        ram_we;
  logic [79:0] ram_di;
  logic        ram_byp_sel;
  logic [79:0] ram_dbyp;
  logic [4:0]  fifo_count;
  logic [31:0] pwrbus_ram_pd;

  nv_ram_rwsthp_19x80_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_dout        (ram_dout),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_byp_sel     (ram_byp_sel),
    .ram_dbyp        (ram_dbyp),
    .fifo_count      (fifo_count),
    .pwrbus_ram_pd   (pwrbus_ram_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with registered address and output register.
  logic [79:0] mem [0:18];
  logic [4:0]  ra_d;
  logic [79:0] dout_r;
  always @(posedge clk) begin
    if (ram_we && ram_wa < 5'd19) mem[ram_wa] <= ram_di;
    if (ram_re) ra_d <= ram_ra;
    if (ram_ore) dout_r <= ram_byp_sel ? ram_dbyp : ((ra_d < 5'd19) ? mem[ra_d] : 80'd0);
  end
  assign ram_dout = dout_r;

  // Reference state
  logic [79:0] q [$];
  int          exp_wa;
  int          exp_ra;
  int          n_acc;
  int          n_pop;
  int          wraps;
  logic        prev_stall;
  logic [79:0] prev_pd;

  int total;
  int bad;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge with inputs stable: checks the cycle, updates the
  // reference, then advances to just after the next rising edge.
  task automatic tick();
    logic [79:0] front;
    check("inv_byp_ore", ram_byp_sel & ~ram_ore, 1'b0);
    check("inv_we_byp", ram_we & ram_byp_sel, 1'b0);
    check("inv_cnt_max", fifo_count > 5'd20, 1'b0);
    check("fifo_count", fifo_count, q.size());
    // With 19 words held the head may or may not be in the output register,
    // so readiness is only fixed for other occupancies.
    if (q.size() != 19) check("wr_prdy", wr_prdy, q.size() != 20);
    if (prev_stall) begin
      check("stall_vld", rd_pvld, 1'b1);
      check("stall_pd", rd_pd, prev_pd);
    end
    if (ram_we) begin
      check("ram_wa", ram_wa, exp_wa);
      if (exp_wa == 18) wraps++;
      exp_wa = (exp_wa + 1) % 19;
    end
    if (ram_re) begin
      check("ram_ra", ram_ra, exp_ra);
      exp_ra = (exp_ra + 1) % 19;
    end
    if (rd_pvld && rd_prdy) begin
      if (q.size() == 0) begin
        check("pop_empty", rd_pvld, 1'b0);
      end else begin
        front = q.pop_front();
        check("rd_pd", rd_pd, front);
      end
      n_pop++;
    end
    if (wr_pvld && wr_prdy) begin
      q.push_back(wr_pd);
      n_acc++;
    end
    prev_stall = rd_pvld & ~rd_prdy;
    prev_pd    = rd_pd;
    @(posedge clk);
    #1;
  endtask

  task automatic run();
    @(negedge clk);
    tick();
  endtask

  task automatic drain();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int c = 0; c < 60 && q.size() != 0; c++) run();
    check("drain_empty", fifo_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int word;
    int acc0;
    int pop0;
    int w0;
    logic acc_now;

    total = 0; bad = 0;
    exp_wa = 0; exp_ra = 0; n_acc = 0; n_pop = 0; wraps = 0;
    prev_stall = 1'b0; prev_pd = '0;
    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    pwrbus_ram_pd = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_pvld", rd_pvld, 1'b0);
    check("rst_wr_prdy", wr_prdy, 1'b1);
    check("rst_we", ram_we, 1'b0);
    check("rst_re", ram_re, 1'b0);
    check("rst_ore", ram_ore, 1'b0);
    check("rst_byp", ram_byp_sel, 1'b0);
    check("rst_count", fifo_count, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single write into an empty FIFO takes the bypass path
    wr_pvld = 1'b1; wr_pd = 80'hA5; rd_prdy = 1'b1;
    @(negedge clk);
    check("t1_byp_sel", ram_byp_sel, 1'b1);
    check("t1_ore", ram_ore, 1'b1);
    check("t1_we", ram_we, 1'b0);
    tick();
    wr_pvld = 1'b0;
    @(negedge clk);
    check("t1_rd_pvld", rd_pvld, 1'b1);
    check("t1_rd_pd", rd_pd, 80'hA5);
    check("t1_count", fifo_count, 1);
    tick();

    // Fill with reader stalled: 0 bypasses, 1..19 go to addresses 0..18
    rd_prdy = 1'b0; wr_pvld = 1'b1; word = 0; acc0 = n_acc;
    for (int c = 0; c < 25; c++) begin
      wr_pd = 80'(word);
      @(negedge clk);
      if (c == 0) check("t2_byp0", ram_byp_sel, 1'b1);
      if (ram_we) check("t2_wa", ram_wa, word - 1);
      acc_now = wr_pvld & wr_prdy;
      tick();
      if (acc_now) word++;
    end
    check("t2_accepts", n_acc - acc0, 20);
    check("t2_wr_prdy", wr_prdy, 1'b0);
    check("t2_count", fifo_count, 20);

    // Drain from full: no bubbles after the first pop, ready returns next cycle
    wr_pvld = 1'b0; rd_prdy = 1'b1; pop0 = n_pop;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) check("t3_prdy_full", wr_prdy, 1'b0);
      if (c == 1) check("t3_prdy_back", wr_prdy, 1'b1);
      if (n_pop - pop0 > 0 && n_pop - pop0 < 20) check("t3_nobubble", rd_pvld, 1'b1);
      tick();
    end
    check("t3_pops", n_pop - pop0, 20);
    check("t3_count", fifo_count, 0);

    // Prefill a few words so streaming goes through the RAM, then stream 100
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      wr_pd = 80'({$urandom, $urandom, $urandom});
      run();
    end
    rd_prdy = 1'b1; acc0 = n_acc; pop0 = n_pop; w0 = wraps;
    for (int c = 0; c < 100; c++) begin
      wr_pd = 80'({$urandom, $urandom, $urandom});
      run();
    end
    check("t4_accepts", n_acc - acc0, 100);
    check("t4_pops", n_pop - pop0, 100);
    check("t4_wraps", (wraps - w0) >= 4, 1'b1);
    drain();

    // Random traffic, 1000 words
    acc0 = n_acc;
    for (int c = 0; c < 20000 && (n_acc - acc0) < 1000; c++) begin
      wr_pvld = ((n_acc - acc0) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = 80'({$urandom, $urandom, $urandom});
      run();
    end
    check("t5_accepts", n_acc - acc0, 1000);
    drain();

    // Reset in the middle of operation
    rd_prdy = 1'b0; wr_pvld = 1'b1;
    for (int c = 0; c < 7; c++) begin
      wr_pd = 80'({$urandom, $urandom, $urandom});
      run();
    end
    wr_pvld = 1'b0;
    run();
    @(negedge clk);
    check("t6_count_pre", fifo_count, 7);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("t6_rd_pvld", rd_pvld, 1'b0);
    check("t6_wr_prdy", wr_prdy, 1'b1);
    check("t6_count", fifo_count, 0);
    q.delete();
    exp_wa = 0; exp_ra = 0; prev_stall = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 80'h1234_5678_9ABC_DEF0_1357;
    @(negedge clk);
    check("t6_byp_after", ram_byp_sel, 1'b1);
    check("t6_we_after", ram_we, 1'b0);
    tick();
    wr_pvld = 1'b0;
    run();
    run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsthp_19x80_ctrl.md
Name: nv_ram_rwsthp_19x80_ctrl

Overview:
- Flow-controlled FIFO controller. It is the client that drives one external nv_ram_rwsthp_19x80 instance: it owns the write port, the registered-address read port, the ore output register and the bypass mux.
- Converts the RAM's two-stage read (re latches address, ore latches data) into a valid/ready read stream with throughput 1/cycle.
- Empty-FIFO writes are forwarded through the dbyp path, so they skip the RAM write.
- Total storage is 20 words: 19 RAM entries plus the RAM output register.

Parameters:
- DEPTH, 19, number of RAM entries.
- WIDTH, 80, payload width.
- AW, 5, address/pointer width; must satisfy 2^AW >= DEPTH+1.

Ports:
- nvdla_core_clk  in  1  core clock; the only clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- wr_pvld  in  1  write valid.
- wr_prdy  out  1  write ready.
- wr_pd  in  WIDTH  write payload.
- rd_pvld  out  1  read valid.
- rd_prdy  in  1  read ready.
- rd_pd  out  WIDTH  read payload; driven directly from ram_dout.
- ram_ra  out  AW  RAM read address.
- ram_re  out  1  RAM read-address enable.
- ram_ore  out  1  RAM output-register enable.
- ram_dout  in  WIDTH  RAM output register.
- ram_wa  out  AW  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_di  out  WIDTH  RAM write data.
- ram_byp_sel  out  1  RAM bypass select.
- ram_dbyp  out  WIDTH  RAM bypass data.
- fifo_count  out  AW  words held: RAM-resident words plus output-register word, range 0..20.
- pwrbus_ram_pd  in  32  power bus; not used internally, routed to the RAM at the top level.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: 0..DEPTH-1, each wraps 18->0.
  - ram_cnt: 0..19, entries written and not yet captured by ore.
  - s1_vld: an address is held in the RAM's ra_d.
  - s2_vld: a word is held in the RAM's dout_r.
- Reset values (async, rstn low): all pointers and counts 0, s1_vld=0, s2_vld=0. Outputs after reset: rd_pvld=0, wr_prdy=1, ram_we=0, ram_re=0, ram_ore=0, ram_byp_sel=0, fifo_count=0.
- Accept/pop:
  - wr_prdy = (ram_cnt != DEPTH). This is combinational from registered state only.
  - wr_acc = wr_pvld & wr_prdy.
  - rd_pvld = s2_vld.
  - pop = rd_pvld & rd_prdy.
- Output stage:
  - s2_free = !s2_vld | rd_prdy.
  - ram_ore = s2_free & (s1_vld | byp).
- Bypass:
  - byp = wr_acc & (ram_cnt==0) & s2_free. ram_cnt==0 implies s1_vld==0.
  - ram_byp_sel = byp, ram_dbyp = wr_pd.
  - No RAM write in a bypass cycle. rd_pvld is seen on the next cycle, so latency is 1.
- RAM write:
  - ram_we = wr_acc & !byp; ram_wa = wr_ptr; ram_di = wr_pd.
  - wr_ptr advances on ram_we.
- Read issue:
  - avail = ram_cnt - s1_vld (entries not yet issued).
  - ram_re = (avail != 0) & (!s1_vld | (ram_ore & !byp)).
  - ram_ra = rd_ptr; rd_ptr advances on ram_re.
  - RAM-path latency, write to rd_pvld: ≥3 cycles (we, re, ore).
- Next-state updates:
  - s1_vld <= ram_re | (s1_vld & !ram_ore).
  - s2_vld <= ram_ore | (s2_vld & !pop).
  - ram_cnt <= ram_cnt + ram_we - (ram_ore & !byp).
- Slot lifetime: a RAM slot is freed only when ore captures it, never at re. A write can never target the address held in ra_d.
- Simultaneous events:
  - Write and ore-capture in the same cycle leave ram_cnt unchanged.
  - When full, a pop in the same cycle does not raise wr_prdy until the next cycle.
- Invariants (bench asserts these):
  - ram_byp_sel only with ram_ore.
  - ram_we and ram_byp_sel never both high.
  - ram_cnt ≤ DEPTH.
  - fifo_count = ram_cnt + s2_vld.
- Ordering: strict FIFO across bypass and RAM paths. Bypass only occurs when no older word is in RAM.
- Stall: rd_pd holds stable while rd_pvld & !rd_prdy, because ore is low.
- Reset mid-operation drops all contents. RAM array contents are don't-care after reset since occupancy is 0.
- Pointer wrap: exactly DEPTH-1 -> 0. Values 19..31 are never produced.

Test Plan:
- Single write 0xA5 with FIFO empty and rd_prdy=1 -> ram_byp_sel=1, ram_ore=1, ram_we=0 in the accept cycle; next cycle rd_pvld=1, rd_pd=0xA5, fifo_count=1.
- rd_prdy=0, write 25 words 0..24 back-to-back:
  - Word 0 goes through bypass; words 1..19 are written to RAM addresses 0..18.
  - wr_prdy falls after the 20th accept; fifo_count=20.
  - Words 20..24 are held off.
- From the full state, hold rd_prdy=1 -> data read out 0..19 in order with no bubbles after the first pop; wr_prdy returns the cycle after ram_cnt drops to 18.
- Continuous streaming with wr_pvld=rd_prdy=1 for 100 words -> 1 word/cycle, pointers wrap 18->0 at least 4 times, output sequence matches input.
- Random rd_prdy (50%) against random wr_pvld, 1000 words -> in-order data, rd_pd stable under stall, all invariants hold.
- Assert rstn low with fifo_count=7 and s1_vld=1 -> immediately rd_pvld=0, wr_prdy=1, fifo_count=0; after release, the next write goes through bypass.
